hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle controller that sequences the shared multiply/divide resource and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU as 32-step iterative operations (shift-add multiply, restoring divide) and MTHI/MTLO as single-cycle writes.
- Generates the pipeline stall for MFHI/MFLO reads and for new mult/div issues while an operation is in flight.
- Sits beside the EX stage; HI_out/LO_out feed the MFHI/MFLO writeback mux.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  issue request from EX; sampled only in IDLE.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- A  input  WIDTH  rs operand (dividend/multiplicand/MTxx source).
- B  input  WIDTH  rt operand (divisor/multiplier).
- ReadHiLo  input  1  decode holds an MFHI/MFLO.
- Flush  input  1  abort in-flight operation.
- Busy  output  1  state != IDLE.
- Stall  output  1  Busy & (ReadHiLo | Start), combinational.
- Done  output  1  one-cycle pulse when HI/LO take a mult/div result.
- HI_out  output  WIDTH  HI register.
- LO_out  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, Reset=0): state=IDLE, counter=0, HI_out=0, LO_out=0, Done=0. Internal accumulators are cleared. Takes effect mid-operation with no completion.
- States: IDLE, CALC, FIX.
  - IDLE, Start and Op in {MULT, MULTU, DIV, DIVU}: latch operands and go to CALC with counter=0. Signed ops latch absolute values and record sign(A) and sign(B).
  - IDLE, Start and Op=MTHI or MTLO: HI_out (resp. LO_out) <= A at the next edge. Stay in IDLE; no Busy, no Done.
  - IDLE, Op=11x: no effect.
  - CALC: one iteration per cycle, counter increments. Leave for FIX after iteration WIDTH-1.
  - FIX: apply sign correction, write HI/LO, assert Done in the following cycle, return to IDLE.
- Latency: Start sampled at edge 0 gives HI/LO updated and Done=1 after edge WIDTH+1 (33 for WIDTH=32). Busy is high for WIDTH+1 cycles.
- Multiply: the 2*WIDTH product goes to HI (upper) and LO (lower). For MULT, the product is negated if sign(A)^sign(B).
- Divide: LO=quotient, HI=remainder. For DIV, the quotient is negated if sign(A)^sign(B), and the remainder takes sign(A).
- Divide by zero (B=0): full latency, LO=all-ones, HI=A (signed and unsigned).
- DIV overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- Start while Busy: ignored, and Stall=1 so EX re-presents it. This also applies to MTHI/MTLO.
- ReadHiLo while Busy: Stall=1. When Done is high, Stall=0 and HI_out/LO_out already carry the new value.
- Flush: in CALC/FIX, return to IDLE at the next edge; HI/LO unchanged; no Done. Flush in IDLE has no effect. Flush has priority over Start in the same cycle.
- Only Done, HI_out and LO_out are registered outputs.

Optional Feature:
- Macro: HILO_EARLY_OUT_EN.
- Defined:
  - MULT/MULTU leave CALC early once the remaining unshifted multiplier bits are all zero, jumping straight to FIX.
  - Minimum latency is 2 cycles when B=0.
  - Results are identical to the full-length operation.
  - Divide latency is unchanged.
- Undefined: every mult/div takes exactly WIDTH+1 cycles.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Done exactly 33 cycles after Start (macro undefined).
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678 in IDLE -> HI_out=0x12345678 next cycle, Busy stays 0. Issue MTLO while a DIVU is busy -> Stall=1, LO unchanged until re-issued after Done.
- Start DIVU 50/7, assert ReadHiLo during CALC -> Stall=1 every busy cycle, Stall=0 in the Done cycle with LO=7, HI=1.
- Flush at CALC cycle 10 -> IDLE next cycle, no Done, HI/LO keep prior values. Reset low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer that owns the HI/LO registers and stalls MFHI/MFLO and new issues while busy.
// Build option HILO_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are all zero.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   opb;
  logic               is_div, is_signed, sign_a, sign_b;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_nxt, mul_nxt, prod;
  logic [WIDTH-1:0]   quo, rmd;
  logic               last_iter, early_exit;

  // MULT and DIV are the even opcodes; signed ops run on magnitudes
  assign op_signed = ~Op[0];
  assign abs_a     = (op_signed & A[WIDTH-1]) ? -A : A;
  assign abs_b     = (op_signed & B[WIDTH-1]) ? -B : B;

  // Restoring divide on {remainder, quotient}; multiply is shift-add with a left-moving multiplicand
  assign diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign div_nxt = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign mul_nxt = opb[0] ? acc + mcand : acc;

  assign last_iter = (cnt == CNT_W'(WIDTH-1));
`ifdef HILO_EARLY_OUT_EN
  assign early_exit = ~is_div & ((opb >> 1) == '0);
`else
  assign early_exit = 1'b0;
`endif

  // A zero divisor leaves all-ones in the quotient; the sign fix must not touch it
  assign prod = (is_signed & (sign_a ^ sign_b)) ? -acc : acc;
  assign quo  = (opb == '0) ? '1 :
                (is_signed & (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd  = (is_signed & sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start & ~Op[2]) state_nxt = CALC;
      CALC:    if (Flush) state_nxt = IDLE;
               else if (last_iter | early_exit) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state != IDLE);
    Stall = Busy & (ReadHiLo | Start);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      HI_out    <= '0;
      LO_out    <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= (state == FIX) & ~Flush;
      case (state)
        IDLE: if (Start) begin
          if (!Op[2]) begin
            is_div    <= Op[1];
            is_signed <= op_signed;
            sign_a    <= op_signed & A[WIDTH-1];
            sign_b    <= op_signed & B[WIDTH-1];
            opb       <= abs_b;
            cnt       <= '0;
            acc       <= Op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
            mcand     <= {{WIDTH{1'b0}}, abs_a};
          end else if (Op[1:0] == 2'b00) begin
            HI_out <= A;
          end else if (Op[1:0] == 2'b01) begin
            LO_out <= A;
          end
        end
        CALC: if (!Flush) begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= div_nxt;
          end else begin
            acc   <= mul_nxt;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
        end
        FIX: if (!Flush) begin
          if (is_div) begin
            HI_out <= rmd;
            LO_out <= quo;
          end else begin
            HI_out <= prod[2*WIDTH-1:WIDTH];
            LO_out <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
